// File: rtl/mem_stage.sv
// Memory-access stage between EX/MEM and MEM/WB: issues loads and stores on a
// req/gnt/rvalid data bus, formats store data, extracts load data, stalls upstream.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        HLT,
    input  logic [31:0] EX_MEM_inst,
    input  logic [31:0] EX_MEM_pc,
    input  logic [31:0] EX_MEM_alu,
    input  logic [31:0] EX_MEM_rs2,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_is_load,
    input  logic        EX_MEM_is_store,
    input  logic        EX_MEM_is_jal,
    input  logic        EX_MEM_is_jalr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] MEM_WB_inst,
    output logic [31:0] MEM_WB_pc,
    output logic [4:0]  MEM_WB_rd,
    output logic [31:0] MEM_WB_wdata,
    output logic        MEM_WB_we,
    output logic [31:0] MEM_fwd_data,
    output logic        MEM_fwd_valid,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        mem_fault,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [31:0] load_buf_q, load_buf_d;
    logic        abort_q, abort_d;
    logic        misalign_q, misalign_d;
    logic        fault_q, fault_d;
    logic [31:0] wb_inst_q, wb_inst_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic        wb_we_q, wb_we_d;

    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic        mem_op;
    logic        misaligned;
    logic        ok;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] wb_value;
    logic        we_cond;
    logic        advance;
    logic        timeout;

    assign funct3  = EX_MEM_inst[14:12];
    assign addr_lo = EX_MEM_alu[1:0];
    assign mem_op  = (EX_MEM_is_load | EX_MEM_is_store) & (EX_MEM_inst != 32'd0);

    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = mem_op & addr_lo[0];
            2'b10:   misaligned = mem_op & (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // After a bus timeout the stalled instruction is retired as a bubble, not retried.
    assign ok = mem_op & ~misaligned & ~abort_q;

    assign dmem_we   = EX_MEM_is_store;
    assign dmem_addr = {EX_MEM_alu[31:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = EX_MEM_rs2;
        case (funct3)
            3'b000: begin
                dmem_be    = 4'b0001 << addr_lo;
                dmem_wdata = {4{EX_MEM_rs2[7:0]}};
            end
            3'b001: begin
                dmem_be    = 4'b0011 << {addr_lo[1], 1'b0};
                dmem_wdata = {2{EX_MEM_rs2[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = EX_MEM_rs2;
            end
        endcase
    end

    always_comb begin
        rd_byte = dmem_rdata[7:0];
        case (addr_lo)
            2'd1:    rd_byte = dmem_rdata[15:8];
            2'd2:    rd_byte = dmem_rdata[23:16];
            2'd3:    rd_byte = dmem_rdata[31:24];
            default: rd_byte = dmem_rdata[7:0];
        endcase
        rd_half  = addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_val = dmem_rdata;
        case (funct3)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        load_buf_d = load_buf_q;
        dmem_req   = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ok && !HLT) begin
                    dmem_req = 1'b1;
                    if (dmem_gnt) begin
                        state_d = EX_MEM_is_store ? DONE : RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                dmem_req = 1'b1;
                if (dmem_gnt) begin
                    state_d = EX_MEM_is_store ? DONE : RESP;
                end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    load_buf_d = load_val;
                    state_d    = DONE;
                end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (!HLT) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            tmo_cnt_d = 8'd0;
        end
        if (RES) begin
            dmem_req = 1'b0;
        end
    end

    assign mem_stall = ((state_q == IDLE) & ok) | (state_q == REQ) | (state_q == RESP)
                     | ((state_q == DONE) & HLT);
    assign advance   = ~HLT & ~mem_stall;

    assign we_cond = (EX_MEM_rd != 5'd0) & (EX_MEM_inst != 32'd0) & ~EX_MEM_is_store
                   & (EX_MEM_inst[6:0] != OPC_BRANCH) & ~misaligned & ~abort_q;

    always_comb begin
        wb_value = EX_MEM_alu;
        if (EX_MEM_is_jal || EX_MEM_is_jalr) begin
            wb_value = EX_MEM_pc + 32'd4;
        end else if (EX_MEM_is_load) begin
            wb_value = load_buf_q;
        end
    end

    assign MEM_fwd_data  = wb_value;
    assign MEM_fwd_valid = we_cond & (~EX_MEM_is_load | (state_q == DONE));

    always_comb begin
        wb_inst_d  = wb_inst_q;
        wb_pc_d    = wb_pc_q;
        wb_rd_d    = wb_rd_q;
        wb_wdata_d = wb_wdata_q;
        wb_we_d    = wb_we_q;
        misalign_d = advance & misaligned;
        fault_d    = timeout;
        abort_d    = abort_q;
        if (advance) begin
            wb_inst_d  = EX_MEM_inst;
            wb_pc_d    = EX_MEM_pc;
            wb_rd_d    = EX_MEM_rd;
            wb_wdata_d = wb_value;
            wb_we_d    = we_cond;
            abort_d    = 1'b0;
        end
        if (timeout) begin
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q    <= IDLE;
            tmo_cnt_q  <= 8'd0;
            load_buf_q <= 32'd0;
            abort_q    <= 1'b0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
            wb_inst_q  <= 32'd0;
            wb_pc_q    <= 32'd0;
            wb_rd_q    <= 5'd0;
            wb_wdata_q <= 32'd0;
            wb_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            load_buf_q <= load_buf_d;
            abort_q    <= abort_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
            wb_inst_q  <= wb_inst_d;
            wb_pc_q    <= wb_pc_d;
            wb_rd_q    <= wb_rd_d;
            wb_wdata_q <= wb_wdata_d;
            wb_we_q    <= wb_we_d;
        end
    end

    assign MEM_WB_inst  = wb_inst_q;
    assign MEM_WB_pc    = wb_pc_q;
    assign MEM_WB_rd    = wb_rd_q;
    assign MEM_WB_wdata = wb_wdata_q;
    assign MEM_WB_we    = wb_we_q;
    assign mem_misalign = misalign_q;
    assign mem_fault    = fault_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage. Consumes the EX_MEM pipeline registers.
- Performs loads and stores over a req/gnt/rvalid data-memory bus: byte enables, store-data replication, load extraction and sign/zero extension.
- Stalls the upstream pipeline while a memory access is in flight.
- Produces the MEM_WB pipeline registers and a forwarding value for the decode/execute bypass.

Parameters:
- TIMEOUT_CYCLES, 64, cycles to wait for dmem_gnt or dmem_rvalid before aborting with mem_fault (1..255).

Ports:
- CLK  in  1  clock; everything synchronous to rising edge
- RES  in  1  reset, synchronous, active-high
- HLT  in  1  global halt; freezes stage registers
- EX_MEM_inst  in  32  instruction in MEM
- EX_MEM_pc  in  32  its PC
- EX_MEM_alu  in  32  ALU result / effective address
- EX_MEM_rs2  in  32  store data
- EX_MEM_rd  in  5  destination register
- EX_MEM_is_load  in  1  load flag
- EX_MEM_is_store  in  1  store flag
- EX_MEM_is_jal  in  1  JAL flag
- EX_MEM_is_jalr  in  1  JALR flag
- dmem_req  out  1  bus request
- dmem_we  out  1  1=write
- dmem_addr  out  32  {EX_MEM_alu[31:2],2'b00}
- dmem_wdata  out  32  replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid; never before the cycle after gnt
- dmem_rdata  in  32  read word
- MEM_WB_inst  out  32  registered instruction
- MEM_WB_pc  out  32  registered PC
- MEM_WB_rd  out  5  registered rd
- MEM_WB_wdata  out  32  registered writeback value
- MEM_WB_we  out  1  registered register-write enable
- MEM_fwd_data  out  32  combinational writeback value of the instruction in MEM
- MEM_fwd_valid  out  1  MEM_fwd_data is usable this cycle
- mem_stall  out  1  combinational; upstream must hold EX_MEM
- mem_misalign  out  1  registered one-cycle pulse, misaligned access dropped
- mem_fault  out  1  registered one-cycle pulse, bus timeout

Behaviour:
- Reset: state IDLE, timeout counter 0, all MEM_WB_* 0, mem_misalign and mem_fault 0. dmem_req is forced 0 during the RES cycle. A bus reply arriving after reset is ignored.
- mem_op = (is_load|is_store) & EX_MEM_inst!=0.
- Misalignment, from funct3[1:0] and addr[1:0]:
  - Halfword (funct3[1:0]=01) is misaligned if addr[0]=1.
  - Word (10) is misaligned if addr[1:0]!=0.
  - ok = mem_op & !misaligned.
- State machine IDLE / REQ / RESP / DONE:
  - IDLE, ok & !HLT: dmem_req=1. Store with gnt -> DONE. Load with gnt -> RESP. No gnt -> REQ.
  - REQ: dmem_req held until gnt. Address, data, be and we must stay stable. Store+gnt -> DONE; load+gnt -> RESP.
  - RESP: on rvalid, capture the extracted load value into an internal buffer -> DONE.
  - DONE: if !HLT, load MEM_WB registers -> IDLE. If HLT, stay in DONE.
  - REQ and RESP continue their handshake even while HLT is high, so no bus response is lost.
  - Timeout: counter increments in REQ and RESP and clears on state change. At TIMEOUT_CYCLES: pulse mem_fault, drop request, MEM_WB_we=0 bubble, go IDLE next cycle with mem_stall=0.
- mem_stall = (IDLE & ok) | REQ | RESP | (DONE & HLT).
  - Minimum stall: store 1 cycle, load 2 cycles.
- Non-memory instructions: MEM_WB registered every cycle where !HLT & !mem_stall. Latency 1, no stall.
- Misaligned access:
  - No bus request is issued.
  - mem_misalign pulses the following cycle.
  - MEM_WB_inst and MEM_WB_pc are captured with MEM_WB_we=0.
- Store formatting (funct3):
  - 000 SB: be=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - 001 SH: be=0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}.
  - 010 SW: be=1111, wdata=rs2.
- Load extraction (funct3), lane chosen by addr:
  - 000 LB: sign-extend selected byte.
  - 001 LH: sign-extend selected half.
  - 100 LBU: zero-extend selected byte.
  - 101 LHU: zero-extend selected half.
  - 010 and all other codes: full word.
- Writeback value: jal|jalr -> pc+4 (mod 2^32); load -> buffered data; else EX_MEM_alu.
- MEM_WB_we = rd!=0 & inst!=0 & !store & opcode!=1100011 (branch) & !misaligned & !timeout.
- MEM_fwd_valid: 1 for a non-load with we conditions met. For a load, 1 only in DONE.

Test Plan:
- ADD result 0x1234, rd=5, no mem op -> next cycle MEM_WB_wdata=0x1234, MEM_WB_we=1; mem_stall never asserted.
- LB at alu=0x103, rdata=0x80AABBCC, gnt in IDLE, rvalid next cycle -> stall 2 cycles; MEM_WB_wdata=0xFFFFFF80. Same stimulus with LBU -> 0x00000080.
- SH at alu=0x202, rs2=0xDEADBEEF, gnt delayed 3 cycles -> dmem_be=1100, wdata=0xBEEFBEEF stable through REQ; MEM_WB_we=0; stall 4 cycles.
- LW at alu=0x101 -> no dmem_req; mem_misalign pulses once; MEM_WB_we=0.
- JAL at pc=0x80000010, rd=1 -> MEM_WB_wdata=0x80000014. JAL at pc=0xFFFFFFFC -> 0x00000000.
- Load, gnt, rvalid withheld -> mem_fault after TIMEOUT_CYCLES, stall released. Separately, RES asserted in RESP -> IDLE next cycle; a later rvalid is ignored and all MEM_WB outputs are 0.
